// File: rtl/sram_ctrl_pkg.sv
// Shared widths, FSM states and the request record for the sram4096x64 front end.
package sram_ctrl_pkg;

  localparam int ADDR_W = 12;
  localparam int DATA_W = 64;
  localparam int MASK_W = DATA_W / 8;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [MASK_W-1:0] wmask;
  } req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; the pointer names the port that wins when both request.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr_q;

  // NOTE: grant gets a default before any condition so this block never infers a latch.
  always_comb begin
    grant = valid;
    if (&valid) grant = ptr_q ? 2'b10 : 2'b01;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= 1'b0;
    end else if (advance && (|grant)) begin
      ptr_q <= grant[0];
    end
  end

endmodule

// File: rtl/sram4096x64_ctrl.sv
// Two-requester front end for one sram6t4096x64 macro: zero-fill after reset,
// then round-robin access with read data one cycle after acceptance.
module sram4096x64_ctrl #(
  parameter int  ADDR_W  = sram_ctrl_pkg::ADDR_W,
  parameter int  DATA_W  = sram_ctrl_pkg::DATA_W,
  parameter bit  INIT_EN = 1'b1,
  localparam int MASK_W  = DATA_W / 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic [MASK_W-1:0] req0_wmask,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  input  logic [MASK_W-1:0] req1_wmask,
  output logic              resp0_valid,
  output logic              resp1_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              init_done,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_i,
  output logic [MASK_W-1:0] sram_wbm,
  output logic              sram_csb,
  output logic              sram_web,
  output logic              sram_oeb,
  input  logic [DATA_W-1:0] sram_o
);

  sram_ctrl_pkg::state_e state_q, state_d;
  sram_ctrl_pkg::req_t   req0, req1, req_sel;

  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              init_done_q;
  logic              resp0_valid_q, resp1_valid_q;
  logic              run_en;
  logic [1:0]        valid, grant;

  // Gating with rst_n drops readies and macro pins to idle the instant reset
  // asserts rather than at the next clock edge.
  assign run_en = init_done_q & rst_n;
  assign valid  = {req1_valid, req0_valid} & {2{run_en}};

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (valid),
    .advance (|valid),
    .grant   (grant)
  );

  assign req0 = '{we: req0_we, addr: req0_addr, wdata: req0_wdata, wmask: req0_wmask};
  assign req1 = '{we: req1_we, addr: req1_addr, wdata: req1_wdata, wmask: req1_wmask};
  assign req_sel = grant[1] ? req1 : req0;

  assign req0_ready  = grant[0];
  assign req1_ready  = grant[1];
  assign resp0_valid = resp0_valid_q;
  assign resp1_valid = resp1_valid_q;
  assign resp_rdata  = sram_o;
  assign init_done   = init_done_q;
  assign sram_oeb    = 1'b0;

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    sram_csb  = 1'b1;
    sram_web  = 1'b1;
    sram_wbm  = '0;
    sram_a    = '0;
    sram_i    = '0;
    if (!rst_n) begin
      // hold the idle pin values while reset is asserted
    end else if (state_q == sram_ctrl_pkg::INIT) begin
      sram_csb  = 1'b0;
      sram_web  = 1'b0;
      sram_wbm  = '1;
      sram_a    = clr_cnt_q;
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (&clr_cnt_q) state_d = sram_ctrl_pkg::RUN;
    end else if (|grant) begin
      sram_csb = 1'b0;
      sram_web = ~req_sel.we;
      sram_wbm = req_sel.we ? req_sel.wmask : '0;
      sram_a   = req_sel.addr;
      sram_i   = req_sel.wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if (INIT_EN) state_q <= sram_ctrl_pkg::INIT;
      else         state_q <= sram_ctrl_pkg::RUN;
      clr_cnt_q     <= '0;
      init_done_q   <= ~INIT_EN;
      resp0_valid_q <= 1'b0;
      resp1_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      init_done_q   <= (state_q == sram_ctrl_pkg::RUN);
      resp0_valid_q <= grant[0] & ~req0_we;
      resp1_valid_q <= grant[1] & ~req1_we;
    end
  end

endmodule

// File: tb/tb_sram4096x64_ctrl.sv
// Self-checking bench for sram4096x64_ctrl with a behavioural macro and a
// word-array reference model for the randomized phase.
module tb_sram4096x64_ctrl;

  localparam logic        T    = 1'b1;
  localparam logic        F    = 1'b0;
  localparam logic [63:0] W0   = 64'h0;
  localparam logic [63:0] A5   = 64'hA5A5_A5A5_A5A5_A5A5;
  localparam logic [63:0] H5A  = 64'h5A5A_5A5A_5A5A_5A5A;
  localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_we;
  logic [11:0] req0_addr;
  logic [63:0] req0_wdata;
  logic [7:0]  req0_wmask;
  logic        req1_valid, req1_ready, req1_we;
  logic [11:0] req1_addr;
  logic [63:0] req1_wdata;
  logic [7:0]  req1_wmask;
  logic        resp0_valid, resp1_valid, init_done;
  logic [63:0] resp_rdata;
  logic [11:0] sram_a;
  logic [63:0] sram_i, sram_o;
  logic [7:0]  sram_wbm;
  logic        sram_csb, sram_web, sram_oeb;

  always #5 clk = ~clk;

  sram4096x64_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_we     (req0_we),
    .req0_addr   (req0_addr),
    .req0_wdata  (req0_wdata),
    .req0_wmask  (req0_wmask),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_we     (req1_we),
    .req1_addr   (req1_addr),
    .req1_wdata  (req1_wdata),
    .req1_wmask  (req1_wmask),
    .resp0_valid (resp0_valid),
    .resp1_valid (resp1_valid),
    .resp_rdata  (resp_rdata),
    .init_done   (init_done),
    .sram_a      (sram_a),
    .sram_i      (sram_i),
    .sram_wbm    (sram_wbm),
    .sram_csb    (sram_csb),
    .sram_web    (sram_web),
    .sram_oeb    (sram_oeb),
    .sram_o      (sram_o)
  );

  // Behavioural macro: never-written words read back as non-zero garbage,
  // so a missing zero-fill shows up on the first read.
  function automatic logic [63:0] expand(input logic [7:0] m);
    logic [63:0] e;
    for (int b = 0; b < 8; b++) e[b*8 +: 8] = {8{m[b]}};
    return e;
  endfunction

  function automatic logic [63:0] garbage(input logic [11:0] a);
    return 64'hDEAD_BEEF_0BAD_F00D ^ {52'b0, a};
  endfunction

  logic [63:0] macro_mem [4096];
  bit          macro_seen [4096];
  logic [63:0] macro_q;
  logic [63:0] macro_old;

  assign sram_o    = macro_q;
  assign macro_old = macro_seen[sram_a] ? macro_mem[sram_a] : garbage(sram_a);

  always @(posedge clk) begin
    if (!sram_csb) begin
      if (!sram_web) begin
        macro_mem[sram_a]  <= (macro_old & ~expand(sram_wbm)) | (sram_i & expand(sram_wbm));
        macro_seen[sram_a] <= 1'b1;
      end else begin
        macro_q <= macro_old;
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_w(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  typedef struct {
    logic        v0, we0;
    logic [11:0] a0;
    logic [63:0] d0;
    logic [7:0]  m0;
    logic        v1, we1;
    logic [11:0] a1;
    logic [63:0] d1;
    logic [7:0]  m1;
    logic        e_rdy0, e_rdy1;
    logic [7:0]  e_wbm;
    logic        e_r0, e_r1;
    logic [63:0] e_data;
  } vec_t;

  vec_t vecs [13];

  task automatic drive(input vec_t v);
    req0_valid = v.v0; req0_we = v.we0; req0_addr = v.a0; req0_wdata = v.d0; req0_wmask = v.m0;
    req1_valid = v.v1; req1_we = v.we1; req1_addr = v.a1; req1_wdata = v.d1; req1_wmask = v.m1;
  endtask

  task automatic idle();
    req0_valid = 1'b0; req0_we = 1'b0; req0_addr = '0; req0_wdata = '0; req0_wmask = '0;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = '0; req1_wdata = '0; req1_wmask = '0;
  endtask

  task automatic wait_init_done(output int cycles);
    cycles = 0;
    for (int k = 1; k <= 5000; k++) begin
      @(posedge clk); #1;
      if (init_done === 1'b1) begin
        cycles = k;
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached before the summary");
    $fatal(1, "watchdog");
  end

  logic [63:0] ref_mem [16];
  int          zaddr  [3] = '{0, 2048, 4095};
  int          saddr  [8] = '{5, 7, 10, 20, 5, 7, 10, 20};
  logic [63:0] sdata  [8];

  initial begin
    int          cycles, g, last_g;
    bit          found, hold0, hold1;
    logic        exp_r0, exp_r1, we;
    logic [11:0] a;
    logic [63:0] d, exp_data;
    logic [7:0]  m;

    vecs[0]  = '{T,T,12'd5, 64'h0123_4567_89AB_CDEF,8'h0F, F,F,12'd0,W0,8'h00, T,F,8'h0F,F,F,W0};
    vecs[1]  = '{T,F,12'd5, W0,8'h00,  F,F,12'd0, W0,8'h00, T,F,8'h00,T,F,64'h0000_0000_89AB_CDEF};
    vecs[2]  = '{F,F,12'd0, W0,8'h00,  T,T,12'd10,A5,8'hFF, F,T,8'hFF,F,F,W0};
    vecs[3]  = '{T,T,12'd20,H5A,8'hFF, F,F,12'd0, W0,8'h00, T,F,8'hFF,F,F,W0};
    vecs[4]  = '{T,T,12'd7, ONES,8'hFF,F,F,12'd0, W0,8'h00, T,F,8'hFF,F,F,W0};
    vecs[5]  = '{F,F,12'd0, W0,8'h00,  T,F,12'd7, W0,8'hFF, F,T,8'h00,F,T,ONES};
    vecs[6]  = '{T,F,12'd10,W0,8'h00,  T,F,12'd20,W0,8'h00, T,F,8'h00,T,F,A5};
    vecs[7]  = '{T,F,12'd10,W0,8'h00,  T,F,12'd20,W0,8'h00, F,T,8'h00,F,T,H5A};
    vecs[8]  = '{T,F,12'd10,W0,8'h00,  T,F,12'd20,W0,8'h00, T,F,8'h00,T,F,A5};
    vecs[9]  = '{T,F,12'd10,W0,8'h00,  T,F,12'd20,W0,8'h00, F,T,8'h00,F,T,H5A};
    vecs[10] = '{F,F,12'd0, W0,8'h00,  T,T,12'd10,W0,8'h00, F,T,8'h00,F,F,W0};
    vecs[11] = '{T,F,12'd10,W0,8'h00,  F,F,12'd0, W0,8'h00, T,F,8'h00,T,F,A5};
    vecs[12] = '{F,F,12'd0, W0,8'h00,  F,F,12'd0, W0,8'h00, F,F,8'h00,F,F,W0};
    sdata = '{64'h0000_0000_89AB_CDEF, ONES, A5, H5A, 64'h0000_0000_89AB_CDEF, ONES, A5, H5A};

    // Power-on reset with both ports pushing writes: everything must stay idle.
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 12'h123; req0_wdata = ONES; req0_wmask = 8'hFF;
    req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 12'h456; req1_wdata = A5;   req1_wmask = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    check_b("rst_csb", sram_csb, 1'b1);
    check_b("rst_web", sram_web, 1'b1);
    check_w("rst_wbm", 64'(sram_wbm), 64'h0);
    check_w("rst_a", 64'(sram_a), 64'h0);
    check_w("rst_i", sram_i, 64'h0);
    check_b("rst_ready0", req0_ready, 1'b0);
    check_b("rst_ready1", req1_ready, 1'b0);
    check_b("rst_resp0", resp0_valid, 1'b0);
    check_b("rst_resp1", resp1_valid, 1'b0);
    check_b("rst_init_done", init_done, 1'b0);
    check_b("rst_oeb", sram_oeb, 1'b0);

    @(negedge clk);
    idle();
    rst_n = 1'b1;
    wait_init_done(cycles);
    check_w("init_done_latency", 64'(cycles), 64'd4097);

    // Zero-fill spot checks.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      idle();
      req0_valid = 1'b1; req0_addr = 12'(zaddr[k]);
      #1;
      check_b($sformatf("zero%0d_ready0", k), req0_ready, 1'b1);
      @(posedge clk); #1;
      check_b($sformatf("zero%0d_resp0", k), resp0_valid, 1'b1);
      check_w($sformatf("zero%0d_data", k), resp_rdata, 64'h0);
    end

    // Directed vectors: masked write, write-then-read, alternation, zero mask.
    for (int k = 0; k < 13; k++) begin
      @(negedge clk);
      drive(vecs[k]);
      #1;
      check_b($sformatf("vec%0d_ready0", k), req0_ready, vecs[k].e_rdy0);
      check_b($sformatf("vec%0d_ready1", k), req1_ready, vecs[k].e_rdy1);
      check_b($sformatf("vec%0d_csb", k), sram_csb, !(vecs[k].e_rdy0 || vecs[k].e_rdy1));
      check_w($sformatf("vec%0d_wbm", k), 64'(sram_wbm), 64'(vecs[k].e_wbm));
      @(posedge clk); #1;
      check_b($sformatf("vec%0d_resp0", k), resp0_valid, vecs[k].e_r0);
      check_b($sformatf("vec%0d_resp1", k), resp1_valid, vecs[k].e_r1);
      if (vecs[k].e_r0 || vecs[k].e_r1)
        check_w($sformatf("vec%0d_data", k), resp_rdata, vecs[k].e_data);
    end

    // Port 1 alone streams eight back-to-back reads.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      idle();
      req1_valid = 1'b1; req1_addr = 12'(saddr[k]);
      #1;
      check_b($sformatf("stream%0d_ready1", k), req1_ready, 1'b1);
      @(posedge clk); #1;
      check_b($sformatf("stream%0d_resp1", k), resp1_valid, 1'b1);
      check_w($sformatf("stream%0d_data", k), resp_rdata, sdata[k]);
    end
    @(negedge clk);
    idle();
    @(posedge clk); #1;
    check_b("stream_end_resp1", resp1_valid, 1'b0);

    // Reset during RUN with a read response in flight.
    @(negedge clk);
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 12'd5;
    @(posedge clk); #1;
    check_b("runrst_resp_before", resp0_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    check_b("runrst_resp_dropped", resp0_valid, 1'b0);
    check_b("runrst_csb", sram_csb, 1'b1);
    check_b("runrst_ready0", req0_ready, 1'b0);
    check_b("runrst_init_done", init_done, 1'b0);
    repeat (2) @(negedge clk);
    idle();
    rst_n = 1'b1;

    // Reset again at clear counter 100.
    found = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (sram_a == 12'd100 && sram_csb == 1'b0) begin
        found = 1'b1;
        break;
      end
    end
    check_b("initrst_cnt100_seen", found, 1'b1);
    rst_n = 1'b0;
    #1;
    check_b("initrst_csb", sram_csb, 1'b1);
    check_b("initrst_init_done", init_done, 1'b0);
    check_w("initrst_a", 64'(sram_a), 64'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    req0_valid = 1'b1;
    #1;
    check_w("restart_a", 64'(sram_a), 64'h0);
    check_b("restart_csb", sram_csb, 1'b0);
    check_b("restart_web", sram_web, 1'b0);
    check_w("restart_wbm", 64'(sram_wbm), 64'hFF);
    check_b("restart_ready0", req0_ready, 1'b0);
    idle();
    wait_init_done(cycles);
    check_w("reinit_latency", 64'(cycles), 64'd4097);

    // Randomized traffic against a word-array model. Array starts cleared,
    // tie-break starts at port 0; an unaccepted request is held stable.
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    last_g = 1;
    hold0  = 1'b0;
    hold1  = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      if (!hold0) begin
        req0_valid = ($urandom_range(0, 3) != 0);
        req0_we    = 1'($urandom_range(0, 1));
        req0_addr  = 12'($urandom_range(0, 15));
        req0_wdata = {$urandom(), $urandom()};
        req0_wmask = 8'($urandom_range(0, 255));
      end
      if (!hold1) begin
        req1_valid = ($urandom_range(0, 3) != 0);
        req1_we    = 1'($urandom_range(0, 1));
        req1_addr  = 12'($urandom_range(0, 15));
        req1_wdata = {$urandom(), $urandom()};
        req1_wmask = 8'($urandom_range(0, 255));
      end
      if (req0_valid && req1_valid) g = 1 - last_g;
      else if (req0_valid)          g = 0;
      else if (req1_valid)          g = 1;
      else                          g = -1;
      #1;
      check_b($sformatf("rnd%0d_ready0", c), req0_ready, g == 0);
      check_b($sformatf("rnd%0d_ready1", c), req1_ready, g == 1);
      check_b($sformatf("rnd%0d_csb", c), sram_csb, g < 0);
      exp_r0   = 1'b0;
      exp_r1   = 1'b0;
      exp_data = '0;
      if (g >= 0) begin
        last_g = g;
        if (g == 0) begin we = req0_we; a = req0_addr; d = req0_wdata; m = req0_wmask; end
        else        begin we = req1_we; a = req1_addr; d = req1_wdata; m = req1_wmask; end
        if (we) begin
          for (int b = 0; b < 8; b++)
            if (m[b]) ref_mem[a[3:0]][b*8 +: 8] = d[b*8 +: 8];
        end else begin
          exp_data = ref_mem[a[3:0]];
          if (g == 0) exp_r0 = 1'b1;
          else        exp_r1 = 1'b1;
        end
      end
      hold0 = req0_valid && (g != 0);
      hold1 = req1_valid && (g != 1);
      @(posedge clk); #1;
      check_b($sformatf("rnd%0d_resp0", c), resp0_valid, exp_r0);
      check_b($sformatf("rnd%0d_resp1", c), resp1_valid, exp_r1);
      if (exp_r0 || exp_r1)
        check_w($sformatf("rnd%0d_data", c), resp_rdata, exp_data);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sram4096x64_ctrl.md
# sram4096x64_ctrl

Two-port front end for one single-port `sram6t4096x64` macro (4096 x 64, byte write mask, registered read).
- After reset, it zero-fills the whole array.
- It then round-robin arbitrates between two valid/ready requesters and returns read data one cycle after acceptance.
- It sits between the client blocks and the macro. The parent instantiates the macro, clocks CE1 from `clk`, and wires it to the `sram_*` pins.

## Interface
- `ADDR_W`, 12, word address width (4096 entries).
- `DATA_W`, 64, data width; `MASK_W` = `DATA_W`/8 (derived, not overridable).
- `INIT_EN`, 1, 1 = zero-fill after reset; 0 = enter RUN immediately.

Ports:
- `clk` in 1: single clock, also the macro CE1.
- `rst_n` in 1: asynchronous, active-low reset.
- `req0_valid` / `req1_valid` in 1: request present.
- `req0_ready` / `req1_ready` out 1: request accepted this cycle.
- `req0_we` / `req1_we` in 1: 1 = write, 0 = read.
- `req0_addr` / `req1_addr` in `ADDR_W`: word address.
- `req0_wdata` / `req1_wdata` in `DATA_W`: write data.
- `req0_wmask` / `req1_wmask` in `MASK_W`: byte enables, bit k covers byte k.
- `resp0_valid` / `resp1_valid` out 1: read data for that port on `resp_rdata`.
- `resp_rdata` out `DATA_W`: shared read data, driven directly from `sram_o`.
- `init_done` out 1: array cleared; requests are accepted.
- `sram_a` out `ADDR_W`, `sram_i` out `DATA_W`, `sram_wbm` out `MASK_W`: macro address, data and mask.
- `sram_csb` out 1: macro chip select, active-low.
- `sram_web` out 1: macro write enable, active-low.
- `sram_oeb` out 1: tied 0.
- `sram_o` in `DATA_W`: macro output.

## Operation
FSM states: INIT, RUN.
- Reset: state = INIT if `INIT_EN` else RUN. Clear counter = 0, rr pointer = port 0.
- Reset values of outputs:
  - `req*_ready` = 0, `resp*_valid` = 0, `init_done` = 0 (1 if `INIT_EN`=0).
  - `sram_csb` = 1, `sram_web` = 1, `sram_wbm` = 0, `sram_a` = 0, `sram_i` = 0.
- INIT, every cycle:
  - Drive `csb`=0, `web`=0, `wbm`=all ones, `i`=0, `a`=counter; counter increments.
  - When counter = 4095 is written: go to RUN; `init_done`=1 from the next cycle.
  - `req*_ready`=0 throughout INIT.
- RUN arbitration:
  - Grant `g` goes to the only valid port, or to the pointer port if both are valid.
  - `req_g_ready`=1, combinationally dependent on `valid`. The other port's ready = 0.
  - Macro pins are driven combinationally from the granted request: `csb`=0, `web`=~we, `wbm`=wmask (reads drive 0), `a`, `i`.
  - No request: `csb`=1.
- Pointer: after any grant to port k, pointer = 1-k. A lone requester therefore gets a grant every cycle.
- Writes produce no response. A write with `wmask`=0 is accepted and changes nothing.
- Reads: `resp_k_valid` is registered and asserts exactly one cycle after acceptance, for one cycle. There is no response backpressure; clients must sink it.
- `resp_rdata` is meaningful only while some `resp*_valid`=1.

## Timing
- Accept to read data: 1 cycle. Macro clock-to-out is 0.3 ns, inside the cycle.
- Throughput: 1 access per cycle total.
- Write then read of the same address on the next cycle returns the new data.
- Both valid: grants alternate strictly, starting from the pointer.
- Async reset mid-INIT or mid-RUN:
  - `csb` goes to 1 immediately and in-flight responses are dropped.
  - INIT restarts from address 0.
- A request held while `ready`=0 must keep addr/data stable; the controller samples only on the accept cycle.

## Structure
- Package `sram_ctrl_pkg`: `ADDR_W`/`DATA_W`/`MASK_W` constants, FSM state enum (INIT, RUN), request struct (we, addr, wdata, wmask).
- Sub-module `rr_arb2`: 2-way round-robin arbiter with a 1-bit pointer register.
  - Inputs: `valid[1:0]`, `advance`. Output: one-hot `grant[1:0]`.
- The top holds the FSM, clear counter, pin mux and response pipeline register.

## Test plan
- Reset with `INIT_EN`=1: `init_done` rises exactly 4097 cycles after reset release. Reading addresses 0, 2048 and 4095 returns 0.
- Port 0 writes 0x0123456789ABCDEF to address 5 with mask 0x0F, then reads address 5 → 0x0000000089ABCDEF.
- Both ports issue continuous reads to addresses 10 and 20: grants alternate 0,1,0,1. `resp0_valid` and `resp1_valid` alternate one cycle later with the correct data.
- Port 1 alone streams 8 reads back-to-back: `req1_ready`=1 every cycle and 8 consecutive `resp1_valid` pulses.
- Write address 7 = 0xFFFF… with mask 0xFF, then read address 7 in the next cycle → 0xFFFF…; no `resp*_valid` is produced for the write.
- Assert `rst_n`=0 at INIT counter 100:
  - `sram_csb`=1 immediately and `init_done`=0.
  - After release, INIT restarts at address 0 and `init_done` rises after the full 4097 cycles.
